// File: rtl/fifo_pixel_packer_pkg.sv
// fifo_pixel_packer_pkg: shared widths, accumulator size and FSM states for the pixel packer
package fifo_pixel_packer_pkg;
  localparam int PIX_W = 24;
  localparam int WORD_W = 32;
  localparam int ACC_BYTES_MAX = 7;
  localparam int ACC_W = 8 * ACC_BYTES_MAX + 0 * PIX_W;
  typedef enum logic [1:0] {RUN, DRAIN, PAD} state_t;
endpackage

// File: rtl/fifo_pixel_packer_axis_out_reg.sv
// axis_out_reg: valid/ready holding register for a 32-bit word plus last
module axis_out_reg
  import fifo_pixel_packer_pkg::*;
(
  input  logic              clk,
  input  logic              tb_rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);
  assign in_ready = !m_valid || m_ready;
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      m_data <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
    end else if (in_valid && in_ready) begin
      m_data <= in_data;
      m_valid <= 1'b1;
      m_last <= in_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fifo_pixel_packer.sv
// fifo_pixel_packer: packs 24-bit FIFO pixels little-endian into 32-bit words with bursts and flush padding
module fifo_pixel_packer
  import fifo_pixel_packer_pkg::*;
#(
  parameter int BURST_WORDS = 16
) (
  input  logic              clk,
  input  logic              tb_rst,
  output logic              fifo_rd_en,
  input  logic [PIX_W-1:0]  fifo_rd_data,
  input  logic              fifo_rd_empty,
  input  logic              flush,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              flush_done
);
  localparam int CW = $clog2(BURST_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BURST_WORDS - 1);
  state_t state, state_n;
  logic [ACC_W-1:0] acc, acc_n, kept;
  logic [2:0] acc_bytes, bytes_n, sb;
  logic [CW-1:0] burst_cnt;
  logic inflight, in_valid, in_last, in_ready, load, drain, pad_load, pad_exit;
  always_comb begin
    fifo_rd_en = !tb_rst && state == RUN && !flush && !fifo_rd_empty &&
                 ({1'b0, acc_bytes} + (inflight ? 4'd3 : 4'd0) <= 4'd4);
    in_valid = (state == PAD) ? acc_bytes != 3'd0 : acc_bytes >= 3'd4;
    in_last = (state == PAD) || burst_cnt == LAST;
    load = in_valid && in_ready;
    drain = load && state != PAD;
    pad_load = load && state == PAD;
    pad_exit = state == PAD && (acc_bytes == 3'd0 || load);
    kept = pad_load ? '0 : drain ? acc >> WORD_W : acc;
    sb = pad_load ? 3'd0 : drain ? acc_bytes - 3'd4 : acc_bytes;
    acc_n = inflight ? kept | (ACC_W'(fifo_rd_data) << {sb, 3'b000}) : kept;
    bytes_n = inflight ? sb + 3'd3 : sb;
    state_n = (state == RUN && flush) ? DRAIN :
              (state == DRAIN && !inflight && acc_bytes < 3'd4) ? PAD :
              pad_exit ? RUN : state;
  end
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state <= RUN;
      acc <= '0;
      acc_bytes <= '0;
      inflight <= 1'b0;
      burst_cnt <= '0;
      flush_done <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      acc_bytes <= bytes_n;
      inflight <= fifo_rd_en;
      flush_done <= pad_exit;
      burst_cnt <= pad_exit ? '0 : drain ? (burst_cnt == LAST ? '0 : burst_cnt + 1'b1) : burst_cnt;
    end
  end
  axis_out_reg u_out (
    .clk(clk),
    .tb_rst(tb_rst),
    .in_valid(in_valid),
    .in_data(acc[WORD_W-1:0]),
    .in_last(in_last),
    .in_ready(in_ready),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_last(m_last),
    .m_ready(m_ready)
  );
endmodule
